atom_access_arbiter: RTL

- Round-robin arbiter and sequencer that shares one read/write stateful atom among NUM_REQ packet requesters.
- Atom semantics: it writes mux(constant, pkt, sel) into its register on every clk edge; its read output is the pre-write value.
- Each cycle this block grants at most one requester and drives that requester's operands to the atom.
- It also owns the atom's programmable constant, returns the old and new register values to the winner one cycle later, and makes the atom hold its value when idle.

---
 rtl/atomsyn_pkg.sv | 16 +
 rtl/atom_access_arbiter_if.sv | 29 ++
 rtl/atom_access_arbiter_rr.sv | 32 +++
 rtl/atom_access_arbiter.sv | 81 ++++++++
 4 files changed

// File: rtl/atomsyn_pkg.sv
// rtl/atomsyn_pkg.sv - shared widths, index-width helper and atom operand bundle
package atomsyn_pkg;

    localparam int COUNT_WIDTH_DEF = 32;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [COUNT_WIDTH_DEF-1:0] constant;
        logic [COUNT_WIDTH_DEF-1:0] pkt;
        logic                       sel;
    } atom_op_t;

endpackage

// File: rtl/atom_access_arbiter_if.sv
// rtl/atom_access_arbiter_if.sv - requester-side request/grant/response bundle
interface atom_access_arbiter_if
    import atomsyn_pkg::*;
#(
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEF,
    parameter int NUM_REQ     = 4,
    parameter int ID_WIDTH    = idx_width(NUM_REQ)
) ();

    logic [NUM_REQ-1:0]             i__req_valid;
    logic [NUM_REQ*COUNT_WIDTH-1:0] i__req_pkt;
    logic [NUM_REQ-1:0]             i__req_sel;
    logic [NUM_REQ-1:0]             o__req_ready;
    logic                           o__resp_valid;
    logic [ID_WIDTH-1:0]            o__resp_id;
    logic [COUNT_WIDTH-1:0]         o__resp_old;
    logic [COUNT_WIDTH-1:0]         o__resp_new;

    modport master (
        output i__req_valid, i__req_pkt, i__req_sel,
        input  o__req_ready, o__resp_valid, o__resp_id, o__resp_old, o__resp_new
    );

    modport slave (
        input  i__req_valid, i__req_pkt, i__req_sel,
        output o__req_ready, o__resp_valid, o__resp_id, o__resp_old, o__resp_new
    );

endinterface

// File: rtl/atom_access_arbiter_rr.sv
// rtl/atom_access_arbiter_rr.sv - combinational round-robin picker, search starts at ptr+1
module rr_arbiter
    import atomsyn_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] idx,
    output logic                any
);

    logic [ID_WIDTH-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_WIDTH'((int'(ptr) + i) % NUM_REQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/atom_access_arbiter.sv
// rtl/atom_access_arbiter.sv - shares one read/write atom among NUM_REQ requesters
module atom_access_arbiter
    import atomsyn_pkg::*;
#(
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEF,
    parameter int NUM_REQ     = 4,
    parameter int ID_WIDTH    = idx_width(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    atom_access_arbiter_if.slave   bus,
    input  logic                   i__cfg_valid,
    input  logic [COUNT_WIDTH-1:0] i__cfg_constant,
    output logic [COUNT_WIDTH-1:0] o__cfg_constant,
    input  logic [COUNT_WIDTH-1:0] i__atom_read,
    output logic [COUNT_WIDTH-1:0] o__atom_constant,
    output logic [COUNT_WIDTH-1:0] o__atom_pkt,
    output logic                   o__atom_sel
);

    logic [ID_WIDTH-1:0]    ptr;
    logic [ID_WIDTH-1:0]    win_idx;
    logic [NUM_REQ-1:0]     grant;
    logic                   any;
    logic                   accept;
    logic [COUNT_WIDTH-1:0] cfg_q;
    logic [COUNT_WIDTH-1:0] win_pkt;
    logic [COUNT_WIDTH-1:0] write_val;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .req   (bus.i__req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (any)
    );

    assign accept           = any & ~rst;
    assign bus.o__req_ready = rst ? '0 : grant;
    assign win_pkt          = bus.i__req_pkt[int'(win_idx)*COUNT_WIDTH +: COUNT_WIDTH];
    assign o__cfg_constant  = cfg_q;
    assign o__atom_constant = cfg_q;

    // Idle (or reset) cycles write the read value back so the atom holds.
    always_comb begin
        o__atom_pkt = i__atom_read;
        o__atom_sel = 1'b1;
        if (accept) begin
            o__atom_pkt = win_pkt;
            o__atom_sel = bus.i__req_sel[win_idx];
        end
    end

    assign write_val = o__atom_sel ? o__atom_pkt : cfg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr               <= ID_WIDTH'(NUM_REQ - 1);
            cfg_q             <= '0;
            bus.o__resp_valid <= 1'b0;
            bus.o__resp_id    <= '0;
            bus.o__resp_old   <= '0;
            bus.o__resp_new   <= '0;
        end else begin
            if (i__cfg_valid) begin
                cfg_q <= i__cfg_constant;
            end
            bus.o__resp_valid <= accept;
            if (accept) begin
                ptr             <= win_idx;
                bus.o__resp_id  <= win_idx;
                bus.o__resp_old <= i__atom_read;
                bus.o__resp_new <= write_val;
            end
        end
    end

endmodule
